// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and widths shared by the I2C master and target
package i2c_pkg;
    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
    } i2c_state_e;
endpackage

// File: rtl/i2c_target_if.sv
// i2c_target_if: pin levels and local byte interface of the I2C target
interface i2c_target_if;
    import i2c_pkg::*;
    logic scl_in;
    logic sda_in;
    logic sda_oe;
    logic [I2C_BYTE_W-1:0] rx_data;
    logic [I2C_BYTE_W-1:0] tx_data;
    logic rx_valid;
    logic tx_load;
    logic busy;
    logic rw_dir;
    modport slave(input scl_in, sda_in, tx_data, output sda_oe, rx_data, rx_valid, tx_load, busy, rw_dir);
    modport master(output scl_in, sda_in, tx_data, input sda_oe, rx_data, rx_valid, tx_load, busy, rw_dir);
endinterface

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: SCL/SDA synchronizer with history flop and bus event strobes
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] scl_s, sda_s;
    logic scl, scl_d, sda_d, sda_chg;
    // all flops reset high so the idle bus never looks like a START
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s <= '1;
            sda_s <= '1;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_s <= {scl_s[SYNC_STAGES-2:0], scl_in};
            sda_s <= {sda_s[SYNC_STAGES-2:0], sda_in};
            scl_d <= scl;
            sda_d <= sda;
        end
    end
    assign scl = scl_s[SYNC_STAGES-1];
    assign sda = sda_s[SYNC_STAGES-1];
    assign sda_chg = sda ^ sda_d;
    assign scl_rise = scl & ~scl_d & ~sda_chg;
    assign scl_fall = ~scl & scl_d & ~sda_chg;
    assign start_det = scl & scl_d & sda_d & ~sda;
    assign stop_det = scl & scl_d & ~sda_d & sda;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: 7-bit addressed I2C responder delivering bytes to a local byte interface
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h31,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic reset,
    i2c_target_if.slave bus
);
    i2c_state_e state;
    logic [2:0] cnt;
    logic [6:0] shreg, txsh;
    logic phase;
    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .reset(reset),
        .scl_in(bus.scl_in),
        .sda_in(bus.sda_in),
        .sda(sda),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start_det(start_det),
        .stop_det(stop_det)
    );

    // phase distinguishes the first and second SCL fall of an ACK slot
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt <= '0;
            shreg <= '0;
            txsh <= '0;
            phase <= 1'b0;
            bus.sda_oe <= 1'b0;
            bus.rx_data <= '0;
            bus.rx_valid <= 1'b0;
            bus.tx_load <= 1'b0;
            bus.busy <= 1'b0;
            bus.rw_dir <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            bus.tx_load <= 1'b0;
            if (stop_det) begin
                state <= ST_IDLE;
                bus.sda_oe <= 1'b0;
                bus.busy <= 1'b0;
            end else if (start_det) begin
                state <= ST_ADDR;
                cnt <= '0;
                bus.sda_oe <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: if (scl_rise) begin
                        shreg <= {shreg[5:0], sda};
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            phase <= 1'b0;
                            if (shreg == TARGET_ADDR) state <= ST_ADDR_ACK;
                            else begin
                                state <= ST_IGNORE;
                                bus.busy <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK: if (scl_fall) begin
                        phase <= 1'b1;
                        if (!phase) begin
                            bus.sda_oe <= 1'b1;
                            bus.busy <= 1'b1;
                            bus.rw_dir <= shreg[0];
                        end else if (bus.rw_dir) begin
                            bus.tx_load <= 1'b1;
                            bus.sda_oe <= ~bus.tx_data[7];
                            txsh <= bus.tx_data[6:0];
                            cnt <= '0;
                            state <= ST_RD_DATA;
                        end else begin
                            bus.sda_oe <= 1'b0;
                            cnt <= '0;
                            state <= ST_WR_DATA;
                        end
                    end
                    ST_WR_DATA: if (scl_rise) begin
                        shreg <= {shreg[5:0], sda};
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            bus.rx_data <= {shreg, sda};
                            bus.rx_valid <= 1'b1;
                            phase <= 1'b0;
                            state <= ST_WR_ACK;
                        end
                    end
                    ST_WR_ACK: if (scl_fall) begin
                        phase <= 1'b1;
                        bus.sda_oe <= ~phase;
                        if (phase) begin
                            cnt <= '0;
                            state <= ST_WR_DATA;
                        end
                    end
                    ST_RD_DATA: if (scl_fall) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            bus.sda_oe <= 1'b0;
                            phase <= 1'b0;
                            state <= ST_RD_ACK;
                        end else begin
                            bus.sda_oe <= ~txsh[6];
                            txsh <= {txsh[5:0], 1'b0};
                        end
                    end
                    ST_RD_ACK: if (scl_rise) begin
                        if (sda) begin
                            bus.sda_oe <= 1'b0;
                            state <= ST_IGNORE;
                        end else phase <= 1'b1;
                    end else if (scl_fall && phase) begin
                        bus.tx_load <= 1'b1;
                        bus.sda_oe <= ~bus.tx_data[7];
                        txsh <= bus.tx_data[6:0];
                        cnt <= '0;
                        state <= ST_RD_DATA;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed I2C master transactions against the target with bench-side expectations
module tb_i2c_target;
    typedef struct {
        logic [6:0] addr;
        logic rw;
        logic [7:0] d0;
        logic [7:0] d1;
        logic hit;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    int rx_cnt = 0;
    int ld_cnt = 0;
    logic [7:0] rx_q[$];
    vec_t vecs[7];
    vec_t v;
    logic ack;
    logic [7:0] rd;
    int rx0, ld0;

    always #5 clk = ~clk;

    i2c_target_if bus();
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_target #(.TARGET_ADDR(7'h31), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_valid) begin
                rx_cnt++;
                rx_q.push_back(bus.rx_data);
            end
            if (bus.tx_load) ld_cnt++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        tick(4);
        scl_m = 1'b1;
        tick(8);
        sda_m = 1'b0;
        tick(8);
        scl_m = 1'b0;
        tick(4);
    endtask

    task automatic stop_c();
        sda_m = 1'b0;
        tick(4);
        scl_m = 1'b1;
        tick(8);
        sda_m = 1'b1;
        tick(8);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;
        tick(4);
        scl_m = 1'b1;
        tick(8);
        scl_m = 1'b0;
        tick(4);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1;
        tick(4);
        scl_m = 1'b1;
        tick(4);
        b = bus.sda_in;
        tick(4);
        scl_m = 1'b0;
        tick(4);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic a);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
    endtask

    initial begin
        vecs[0] = '{7'h31, 1'b0, 8'hA5, 8'h3C, 1'b1};
        vecs[1] = '{7'h22, 1'b0, 8'hA5, 8'h3C, 1'b0};
        vecs[2] = '{7'h31, 1'b1, 8'h96, 8'h0F, 1'b1};
        vecs[3] = '{7'h30, 1'b1, 8'h96, 8'h0F, 1'b0};
        vecs[4] = '{7'h31, 1'b0, 8'h00, 8'hFF, 1'b1};
        vecs[5] = '{7'h31, 1'b1, 8'hFF, 8'h00, 1'b1};
        vecs[6] = '{7'h71, 1'b0, 8'h55, 8'hAA, 1'b0};
        bus.tx_data = 8'h00;
        tick(4);
        chk("rst_sda_oe", 8'(bus.sda_oe), 8'h00);
        chk("rst_rx_data", bus.rx_data, 8'h00);
        chk("rst_rx_valid", 8'(bus.rx_valid), 8'h00);
        chk("rst_tx_load", 8'(bus.tx_load), 8'h00);
        chk("rst_busy", 8'(bus.busy), 8'h00);
        chk("rst_rw_dir", 8'(bus.rw_dir), 8'h00);
        reset = 1'b0;
        tick(10);

        for (int k = 0; k < 7; k++) begin
            v = vecs[k];
            rx0 = rx_cnt;
            ld0 = ld_cnt;
            rx_q.delete();
            if (v.rw) bus.tx_data = v.d0;
            start_c();
            write_byte({v.addr, v.rw}, ack);
            chk("addr_ack", 8'(ack), 8'(!v.hit));
            chk("busy_addr", 8'(bus.busy), 8'(v.hit));
            if (v.hit) chk("rw_dir", 8'(bus.rw_dir), 8'(v.rw));
            if (v.hit && !v.rw) begin
                write_byte(v.d0, ack);
                chk("d0_ack", 8'(ack), 8'h00);
                write_byte(v.d1, ack);
                chk("d1_ack", 8'(ack), 8'h00);
            end
            if (v.hit && v.rw) begin
                read_byte(rd);
                chk("rd0", rd, v.d0);
                bus.tx_data = v.d1;
                write_bit(1'b0);
                read_byte(rd);
                chk("rd1", rd, v.d1);
                write_bit(1'b1);
                chk("nack_release", 8'(bus.sda_oe), 8'h00);
            end
            stop_c();
            tick(4);
            chk("busy_stop", 8'(bus.busy), 8'h00);
            chk("sda_oe_stop", 8'(bus.sda_oe), 8'h00);
            chk("rx_count", 8'(rx_cnt - rx0), (v.hit && !v.rw) ? 8'd2 : 8'd0);
            chk("ld_count", 8'(ld_cnt - ld0), (v.hit && v.rw) ? 8'd2 : 8'd0);
            if (v.hit && !v.rw) begin
                chk("rx_byte0", rx_q.size() > 0 ? rx_q[0] : 8'hxx, v.d0);
                chk("rx_byte1", rx_q.size() > 1 ? rx_q[1] : 8'hxx, v.d1);
            end
            tick(8);
        end

        // write register index, repeated START, then read with no STOP between
        rx0 = rx_cnt;
        ld0 = ld_cnt;
        rx_q.delete();
        start_c();
        write_byte(8'h62, ack);
        chk("rs_waddr_ack", 8'(ack), 8'h00);
        chk("rs_rw_dir_w", 8'(bus.rw_dir), 8'h00);
        write_byte(8'h10, ack);
        chk("rs_reg_ack", 8'(ack), 8'h00);
        bus.tx_data = 8'hC3;
        start_c();
        write_byte(8'h63, ack);
        chk("rs_raddr_ack", 8'(ack), 8'h00);
        chk("rs_rw_dir_r", 8'(bus.rw_dir), 8'h01);
        chk("rs_busy", 8'(bus.busy), 8'h01);
        read_byte(rd);
        chk("rs_rd", rd, 8'hC3);
        write_bit(1'b1);
        stop_c();
        tick(4);
        chk("rs_rx_count", 8'(rx_cnt - rx0), 8'd1);
        chk("rs_rx_byte", rx_q.size() > 0 ? rx_q[0] : 8'hxx, 8'h10);
        chk("rs_ld_count", 8'(ld_cnt - ld0), 8'd1);
        tick(8);

        // STOP after four data bits aborts the byte
        rx0 = rx_cnt;
        start_c();
        write_byte(8'h62, ack);
        chk("ab_addr_ack", 8'(ack), 8'h00);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        stop_c();
        tick(4);
        chk("ab_busy", 8'(bus.busy), 8'h00);
        chk("ab_sda_oe", 8'(bus.sda_oe), 8'h00);
        chk("ab_rx_count", 8'(rx_cnt - rx0), 8'd0);
        tick(8);

        // reset while the target is driving the address ACK
        start_c();
        for (int i = 7; i >= 0; i--) write_bit(8'h62 >> i);
        chk("rr_ack_driven", 8'(bus.sda_oe), 8'h01);
        reset = 1'b1;
        tick(1);
        chk("rr_sda_oe", 8'(bus.sda_oe), 8'h00);
        chk("rr_busy", 8'(bus.busy), 8'h00);
        reset = 1'b0;
        read_bit(ack);
        chk("rr_ack_slot", 8'(ack), 8'h01);
        stop_c();
        tick(8);
        rx0 = rx_cnt;
        rx_q.delete();
        start_c();
        write_byte(8'h62, ack);
        chk("rr_addr_ack", 8'(ack), 8'h00);
        write_byte(8'h5A, ack);
        chk("rr_data_ack", 8'(ack), 8'h00);
        stop_c();
        tick(4);
        chk("rr_rx_count", 8'(rx_cnt - rx0), 8'd1);
        chk("rr_rx_byte", rx_q.size() > 0 ? rx_q[0] : 8'hxx, 8'h5A);
        chk("rr_busy_stop", 8'(bus.busy), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (responder) that services the bus driven by the team's I2C master. It samples SCL/SDA with the system clock and detects START, repeated START and STOP. It matches a 7-bit address, ACKs by pulling SDA low, and delivers written bytes to a local byte interface. On reads it returns bytes supplied by local logic. It sits between the board pins (via an open-drain pad) and a register file or sensor-emulation model.

## Interface
- `TARGET_ADDR`, default 7'h31: 7-bit address this target answers to.
- `SYNC_STAGES`, default 2: synchronizer flops on `scl_in`/`sda_in`; minimum 2.
- `clk` in 1: system clock; must be at least 8x the SCL rate.
- `reset` in 1: synchronous, active-high reset.
- `scl_in` in 1: SCL pin level; asynchronous.
- `sda_in` in 1: SDA pin level; asynchronous.
- `sda_oe` out 1: 1 drives SDA low (open-drain). 0 releases SDA.
- `rx_data` out 8: last byte written by the master.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `tx_data` in 8: byte to return on a read; must be stable when sampled.
- `tx_load` out 1: one-cycle pulse marking the cycle `tx_data` is sampled.
- `busy` out 1: 1 from an address match until STOP or a START that does not match.
- `rw_dir` out 1: R/W bit of the current transfer (1 = read). Valid while `busy`.

## Operation
- Front end:
  - `scl_in`/`sda_in` pass through `SYNC_STAGES` flops, then a one-flop history.
  - This yields `scl_rise`, `scl_fall`, `start_det` (SDA falls while SCL high) and `stop_det` (SDA rises while SCL high).
- Bit order is MSB first. SDA is sampled on `scl_rise`. `sda_oe` changes only on `scl_fall`.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
  - IDLE: wait for `start_det`, then go to ADDR with the bit counter at 0.
  - ADDR: shift 8 bits (7 address bits, then R/W).
    - After the 8th `scl_rise`: address equals `TARGET_ADDR` → ADDR_ACK.
    - No match → IGNORE.
  - ADDR_ACK: on the first `scl_fall`, set `sda_oe`=1, set `busy`=1 and latch `rw_dir`. On the second `scl_fall`:
    - Write (`rw_dir`=0): release SDA → WR_DATA.
    - Read (`rw_dir`=1): pulse `tx_load`, capture `tx_data`, drive bit 7 (`sda_oe` = ~bit) → RD_DATA.
  - WR_DATA: shift 8 bits. At the 8th `scl_rise`, update `rx_data` and pulse `rx_valid` → WR_ACK.
  - WR_ACK: drive `sda_oe` from the next `scl_fall` to the following `scl_fall`, then release → WR_DATA. The target always ACKs.
  - RD_DATA: on each `scl_fall` present the next bit, as `sda_oe` = ~bit. After bit 0 has been held for its clock, the next `scl_fall` releases SDA → RD_ACK.
  - RD_ACK: sample SDA on `scl_rise`.
    - SDA=0 (ACK): on the next `scl_fall`, pulse `tx_load`, capture a new byte, drive its bit 7 → RD_DATA.
    - SDA=1 (NACK): release SDA → IGNORE.
  - IGNORE: `sda_oe`=0 and no outputs change. Wait for START or STOP.
- Priority:
  - `stop_det` in any state → IDLE, `sda_oe`=0, `busy`=0.
  - `start_det` in any state (repeated START) → ADDR, bit counter cleared, `sda_oe`=0.
  - START/STOP take precedence over an SCL edge in the same cycle. SCL and SDA cannot both change in one sample without glitch filtering; SCL-edge processing is suppressed in that cycle.
- Reset: state=IDLE and synchronizer flops all load 1 (bus idle), so no false START follows reset release. Outputs: `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_load`=0, `busy`=0, `rw_dir`=0.
- Reset asserted mid-transfer releases SDA on the next `clk`. The target then ignores the bus until the next START.

## Timing
- Pin-to-event latency: `SYNC_STAGES`+1 cycles (3 at default).
- `sda_oe` changes 1 `clk` after the detected `scl_fall`. This is well within SCL low time at 8x oversampling.
- `rx_valid` asserts 1 `clk` after the 8th data `scl_rise` is detected. `rx_data` holds until the next byte.
- `tx_data` is sampled in the `tx_load` cycle. Local logic has one full byte time to prepare the next byte.
- Back-to-back bytes with no gap are supported. The bit counter wraps 7→0 per byte.

## Structure
- Shared package/include `i2c_pkg`: state encoding, `I2C_ADDR_W`=7, `I2C_BYTE_W`=8. The master uses the same package.
- Sub-module `i2c_sync_edge`: synchronizer plus history flops. Outputs filtered `scl`/`sda` and the four event strobes.
- Top: FSM, shift register, 3-bit bit counter, output registers.

## Test plan
- Write to 0x31, data 0xA5 then 0x3C, STOP → `sda_oe` ACK pulses after the address and after each byte. `rx_valid` pulses twice: `rx_data`=0xA5, then 0x3C. `busy` falls on STOP.
- Write to 0x22 → no ACK (`sda_oe` stays 0), no `rx_valid`, `busy`=0.
- Read from 0x31 with `tx_data`=0x96, master ACKs, then `tx_data`=0x0F, master NACKs → SDA bits 1001_0110 then 0000_1111, two `tx_load` pulses, SDA released after the NACK.
- Write 0x31 with register byte 0x10, repeated START, then read 0x31 → `rw_dir` goes 0→1 and one `rx_valid` (0x10). Read data follows with no STOP in between.
- STOP injected after 4 data bits → IDLE, `sda_oe`=0, no `rx_valid`.
- `reset` asserted while the target drives an ACK → `sda_oe`=0 the next cycle. A subsequent write to 0x31 completes normally.
